alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
- Multi-cycle sequencer that performs wide add/subtract by streaming 4-bit nibbles through one 4-bit lookahead-carry slice, least-significant nibble first.
- The carry-out of each nibble is held in a flip-flop and fed back as the next nibble's carry-in.
- Trades latency for area. Sits between the central-unit instruction decode and the register file.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES. Legal range is 2..16.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  1  0 = ADD, 1 = SUB (A - B); captured with start.
- a  in  W  operand A; captured with start.
- b  in  W  operand B; captured with start.
- cin  in  1  external carry-in for ADD; ignored for SUB, which forces carry-in = 1.
- abort  in  1  synchronous abort.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse when result is valid.
- result  out  W  sum or difference; held until the next accepted start.
- cout  out  1  final carry-out; for SUB, 1 means no borrow.
- ovf  out  1  signed overflow of the W-bit operation.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, nibble index = 0, carry FF = 0, busy = 0, done = 0, result = 0, cout = 0, ovf = 0.
- FSM states:
  - IDLE: start=1 → capture a, op, and b (stored inverted if op=1); carry FF ← (op ? 1 : cin); index ← 0; go to RUN.
  - RUN: each cycle the slice processes nibble[index]:
    - g = a_n & b_n, p = a_n | b_n.
    - c[i+1] = g[i] | p[i] & c[i], fully lookahead-expanded.
    - sum = a_n ^ b_n ^ c.
    - Write the sum nibble into result[4*index +: 4]; carry FF ← c[4]; index++.
    - After index = NIBBLES-1 is processed, go to DONE.
  - DONE: done = 1 for exactly one cycle; cout = carry FF; ovf = c[4] ^ c[3] of the top nibble, registered during the last RUN cycle. Next state is IDLE.
- Latency: start sampled at edge 0; done is high in the cycle following edge NIBBLES+1.
- Throughput: one operation per NIBBLES+2 cycles; start may be reasserted in the cycle after DONE.
- start while busy: ignored, not queued. Operands must not be assumed stable after the capture edge.
- abort in RUN or DONE: next state is IDLE, with no done pulse. result holds partial content; cout and ovf are cleared to 0. abort in IDLE has no effect. abort has priority over start.
- Operand registers are cleared on reset only.
- result is written nibble-wise during RUN, so it is not valid until done. The bench must only check result at done.
- Arithmetic is modulo 2^W. No saturation.

Optional Feature:
- Macro ALU_SEQ_ZERO_FLAG_EN.
- When defined: adds output `zero` (1 bit).
  - Cleared when start is accepted.
  - Accumulated as the AND of (sum nibble == 0) across all RUN cycles.
  - Valid with done and held until the next start.
  - Reset value 0; abort clears it to 0.
- When not defined: the port and its logic are absent; the rest of the interface and behaviour is identical.

Decomposition:
- Package alu_seq_pkg holds:
  - Opcode constants OP_ADD = 1'b0 and OP_SUB = 1'b1.
  - The FSM state enum: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - Localparam NIB = 4.
- One sub-module, nibble_slice: combinational 4-bit generate/propagate plus lookahead carry and sum.
  - Inputs: a_n[3:0], b_n[3:0], c_in.
  - Outputs: s[3:0], c_out, c3 (carry into bit 3, for overflow).
- The sequencer itself holds the FSM, index counter, carry FF, and operand/result registers.

Test Plan:
- ADD with NIBBLES=4, a=16'h1234, b=16'h0FCD, cin=0 → done at cycle 6; result=16'h2201, cout=0, ovf=0.
- Carry ripple across all nibbles: ADD a=16'hFFFF, b=16'h0001, cin=0 → result=16'h0000, cout=1, ovf=0; with ALU_SEQ_ZERO_FLAG_EN, zero=1.
- SUB a=16'h8000, b=16'h0001 → result=16'h7FFF, cout=1, ovf=1.
- SUB a=16'h0003, b=16'h0005 → result=16'hFFFE, cout=0 (borrow), ovf=0.
- start pulsed in RUN with new operands → ignored; the first operation's result is unchanged. Back-to-back start in the cycle after DONE → accepted.
- Abort and reset:
  - abort asserted in the second RUN cycle → no done pulse; IDLE next cycle; busy=0; cout=0.
  - rst_n dropped mid-RUN, asynchronously between edges → all outputs 0 immediately.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcodes, FSM state encoding and nibble width for alu_seq_ctrl
package alu_seq_pkg;
  localparam int NIB = 4;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/alu_seq_ctrl_nibble_slice.sv
// nibble_slice: combinational 4-bit lookahead-carry adder slice
// Ports: a_n, b_n - operand nibbles; c_in - carry into bit 0;
//        s - sum nibble; c_out - carry out of bit 3; c3 - carry into bit 3 (overflow detect)
module nibble_slice (
  input  logic [3:0] a_n,
  input  logic [3:0] b_n,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out,
  output logic       c3
);
  logic [3:0] g, p;
  logic c1, c2;
  assign g = a_n & b_n;
  assign p = a_n | b_n;
  assign c1 = g[0] | (p[0] & c_in);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
  assign c_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c_in);
  assign s = a_n ^ b_n ^ {c3, c2, c1, c_in};
endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: nibble-serial wide add/subtract sequencer built around one 4-bit lookahead slice
// Ports: clk, rst_n (async, active-low); start/op/a/b/cin request captured in IDLE; abort cancels RUN/DONE;
//        busy (RUN or DONE), done (one-cycle pulse), result, cout (SUB: 1 = no borrow), ovf (signed overflow).
// Optional: define ALU_SEQ_ZERO_FLAG_EN to add output zero (result == 0, valid with done).
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 op,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic                 ovf
`ifdef ALU_SEQ_ZERO_FLAG_EN
  ,
  output logic                 zero
`endif
);
  localparam int W = NIB * NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  state_t state;
  logic [IW-1:0] idx;
  logic [W-1:0] a_q, b_q;
  logic carry, last, c_out, c3;
  logic [NIB-1:0] a_n, b_n, s;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic zacc;
`endif
  assign a_n = a_q[NIB*idx +: NIB];
  assign b_n = b_q[NIB*idx +: NIB];
  assign last = idx == IW'(NIBBLES - 1);
  nibble_slice u_slice (
    .a_n  (a_n),
    .b_n  (b_n),
    .c_in (carry),
    .s    (s),
    .c_out(c_out),
    .c3   (c3)
  );
  // SUB is A + ~B + 1: B is stored inverted and the carry FF is seeded with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      zero   <= 1'b0;
      zacc   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state != IDLE && abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        cout  <= 1'b0;
        ovf   <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
        zero  <= 1'b0;
`endif
      end else if (state == IDLE) begin
        if (start) begin
          a_q   <= a;
          b_q   <= op == OP_SUB ? ~b : b;
          carry <= op == OP_ADD ? cin : 1'b1;
          idx   <= '0;
          busy  <= 1'b1;
          state <= RUN;
`ifdef ALU_SEQ_ZERO_FLAG_EN
          zero  <= 1'b0;
          zacc  <= 1'b1;
`endif
        end
      end else if (state == RUN) begin
        result[NIB*idx +: NIB] <= s;
        carry <= c_out;
        idx   <= last ? '0 : idx + 1'b1;
`ifdef ALU_SEQ_ZERO_FLAG_EN
        zacc  <= zacc & (s == '0);
`endif
        if (last) begin
          ovf   <= c_out ^ c3;
          state <= DONE;
        end
      end else begin
        done  <= 1'b1;
        cout  <= carry;
        busy  <= 1'b0;
        state <= IDLE;
`ifdef ALU_SEQ_ZERO_FLAG_EN
        zero  <= zacc;
`endif
      end
    end
  end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed self-checking bench for alu_seq_ctrl (NIBBLES = 4)
module tb_alu_seq_ctrl;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, op = 1'b0, cin = 1'b0, abort = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, cout, ovf;
  logic [W-1:0] result;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic zero;
`endif
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  alu_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .result(result),
    .cout  (cout),
    .ovf   (ovf)
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    .zero  (zero)
`endif
  );
  // Drives a request that the next rising edge samples, then scrambles the inputs.
  task automatic launch(input logic o, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    start = 1'b1; op = o; a = x; b = y; cin = ci;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; cin = ~ci; a = W'($urandom); b = W'($urandom);
  endtask
  // Counts rising edges until done is seen, -1 if it never comes.
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!done && cyc < 40);
    if (!done) cyc = -1;
  endtask
  task automatic test_reset;
    #12;
    n_cmp++;
    if ({busy, done, cout, ovf, result} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b done=%b cout=%b ovf=%b result=%h, want all 0", busy, done, cout, ovf, result);
    end
`ifdef ALU_SEQ_ZERO_FLAG_EN
    n_cmp++;
    if (zero !== 1'b0) begin n_err++; $display("FAIL reset_zero: got %b want 0", zero); end
`endif
    @(negedge clk); rst_n = 1'b1;
  endtask
  task automatic test_add;
    int cyc;
    @(negedge clk);
    launch(1'b0, 16'h1234, 16'h0FCD, 1'b0);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL add_busy: got %b want 1", busy); end
    wait_done(cyc);
    n_cmp++;
    if (cyc !== NIBBLES + 1) begin n_err++; $display("FAIL add_latency: got %0d edges want %0d", cyc, NIBBLES + 1); end
    n_cmp++;
    if ({result, cout, ovf, busy} !== {16'h2201, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL add_1234_0fcd: got result=%h cout=%b ovf=%b busy=%b want 2201 0 0 0", result, cout, ovf, busy);
    end
`ifdef ALU_SEQ_ZERO_FLAG_EN
    n_cmp++;
    if (zero !== 1'b0) begin n_err++; $display("FAIL add_zero: got %b want 0", zero); end
`endif
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL done_pulse_width: got %b want 0", done); end
    launch(1'b0, 16'h7FFF, 16'h0000, 1'b1);
    wait_done(cyc);
    n_cmp++;
    if ({result, cout, ovf} !== {16'h8000, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL add_cin_ovf: got result=%h cout=%b ovf=%b want 8000 0 1", result, cout, ovf);
    end
    launch(1'b0, 16'h8000, 16'h8000, 1'b0);
    wait_done(cyc);
    n_cmp++;
    if ({result, cout, ovf} !== {16'h0000, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL add_neg_ovf: got result=%h cout=%b ovf=%b want 0000 1 1", result, cout, ovf);
    end
  endtask
  task automatic test_carry_ripple;
    int cyc;
    @(negedge clk);
    launch(1'b0, 16'hFFFF, 16'h0001, 1'b0);
    wait_done(cyc);
    n_cmp++;
    if ({result, cout, ovf} !== {16'h0000, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL ripple_ffff_0001: got result=%h cout=%b ovf=%b want 0000 1 0", result, cout, ovf);
    end
`ifdef ALU_SEQ_ZERO_FLAG_EN
    n_cmp++;
    if (zero !== 1'b1) begin n_err++; $display("FAIL ripple_zero: got %b want 1", zero); end
`endif
  endtask
  task automatic test_sub;
    int cyc;
    @(negedge clk);
    launch(1'b1, 16'h8000, 16'h0001, 1'b0);
    wait_done(cyc);
    n_cmp++;
    if ({result, cout, ovf} !== {16'h7FFF, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL sub_8000_0001: got result=%h cout=%b ovf=%b want 7fff 1 1", result, cout, ovf);
    end
    launch(1'b1, 16'h0003, 16'h0005, 1'b0);
    wait_done(cyc);
    n_cmp++;
    if ({result, cout, ovf} !== {16'hFFFE, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL sub_borrow: got result=%h cout=%b ovf=%b want fffe 0 0", result, cout, ovf);
    end
    launch(1'b1, 16'h0005, 16'h0005, 1'b0);
    wait_done(cyc);
    n_cmp++;
    if ({result, cout, ovf} !== {16'h0000, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL sub_equal_cin_ignored: got result=%h cout=%b ovf=%b want 0000 1 0", result, cout, ovf);
    end
`ifdef ALU_SEQ_ZERO_FLAG_EN
    n_cmp++;
    if (zero !== 1'b1) begin n_err++; $display("FAIL sub_zero: got %b want 1", zero); end
`endif
  endtask
  task automatic test_back_to_back;
    int cyc;
    @(negedge clk);
    launch(1'b0, 16'h1234, 16'h0FCD, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; op = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc);
    n_cmp++;
    if (cyc !== NIBBLES - 1) begin n_err++; $display("FAIL ignored_start_latency: got %0d edges want %0d", cyc, NIBBLES - 1); end
    n_cmp++;
    if (result !== 16'h2201) begin n_err++; $display("FAIL ignored_start_result: got %h want 2201", result); end
    launch(1'b1, 16'h8000, 16'h0001, 1'b0);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept_busy: got %b want 1", busy); end
    wait_done(cyc);
    n_cmp++;
    if (cyc !== NIBBLES + 1) begin n_err++; $display("FAIL b2b_latency: got %0d edges want %0d", cyc, NIBBLES + 1); end
    n_cmp++;
    if ({result, cout, ovf} !== {16'h7FFF, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL b2b_result: got result=%h cout=%b ovf=%b want 7fff 1 1", result, cout, ovf);
    end
  endtask
  task automatic test_abort;
    logic seen;
    @(negedge clk);
    launch(1'b0, 16'hFFFF, 16'h0001, 1'b0);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_cmp++;
    if ({busy, done, cout, ovf} !== 4'b0000) begin
      n_err++;
      $display("FAIL abort_state: got busy=%b done=%b cout=%b ovf=%b want 0 0 0 0", busy, done, cout, ovf);
    end
    seen = 1'b0;
    repeat (NIBBLES + 3) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL abort_no_done: got activity=%b want 0", seen); end
  endtask
  task automatic test_async_reset;
    int cyc;
    @(negedge clk);
    launch(1'b0, 16'h1234, 16'h0FCD, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, cout, ovf, result} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got busy=%b done=%b cout=%b ovf=%b result=%h want all 0", busy, done, cout, ovf, result);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    launch(1'b0, 16'h7FFF, 16'h0000, 1'b1);
    wait_done(cyc);
    n_cmp++;
    if ({result, cout, ovf} !== {16'h8000, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL post_reset_add: got result=%h cout=%b ovf=%b want 8000 0 1", result, cout, ovf);
    end
  endtask
  initial begin
    test_reset();
    test_add();
    test_carry_ripple();
    test_sub();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
